// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor (optional saturation via SEQ_ADDSUB_SAT_EN).
// FSM encoding, a counter-width helper and the single-bit full-adder cell used by the chunk adder.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, never smaller than 1 so a one-chunk configuration still has a counter bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Single-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle between the register-read stage and the sequential adder.
interface seq_addsub_if #(
  parameter int N = 32
);
  // A transfer happens on a rising edge where valid && ready; the sender holds its payload
  // stable while valid is high and ready is low, and ready never depends on valid.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, zero
  );
endinterface

// File: rtl/addsub_chunk.sv
// W-bit combinational ripple adder built from the package full-adder cell; also exports the
// carry into its MSB so the caller can form the signed-overflow flag.
module addsub_chunk
  import seq_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);
  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {c[i+1], s_o[i]} = full_add(a_i[i], b_i[i], c[i]);
  end

  assign c_o     = c[W];
  assign c_msb_o = c[W-1];
endmodule

// File: rtl/seq_addsub.sv
// Sequential N-bit adder/subtractor, W bits per cycle through one shared ripple chunk.
// Defining SEQ_ADDSUB_SAT_EN saturates the result on signed overflow.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic   clk,
  input  logic   rst,
  seq_addsub_if.slave io,
  output state_e dbg_state_o
);
  localparam int            CHUNKS = N / W;
  localparam int            CW     = clog2_min1(CHUNKS);
  localparam logic [CW-1:0] LAST   = CW'(CHUNKS - 1);

  state_e        state_q;
  logic [N-1:0]  a_q, b_q, res_q, sum_q;
  logic          carry_q, c_out_q, ovf_q, zero_q;
  logic          in_ready_q, out_valid_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  s;
  logic          cy, c_msb;
  logic [N-1:0]  res_d, sum_d;
  logic          ovf_d;

  addsub_chunk #(.W(W)) u_chunk (
    .a_i     (a_q[W-1:0]),
    .b_i     (b_q[W-1:0]),
    .c_i     (carry_q),
    .s_o     (s),
    .c_o     (cy),
    .c_msb_o (c_msb)
  );

  // New chunk enters at the top so after CHUNKS shifts chunk 0 sits at bit 0.
  assign res_d = (res_q >> W) | (N'(s) << (N - W));
  assign ovf_d = c_msb ^ cy;

  // On the last chunk a_q[W-1] is the original sign bit of A.
`ifdef SEQ_ADDSUB_SAT_EN
  assign sum_d = !ovf_d ? res_d :
                 (a_q[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
  assign sum_d = res_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid && in_ready_q) begin
            a_q        <= io.a;
            b_q        <= io.sub ? ~io.b : io.b;
            carry_q    <= io.sub ^ io.c_in;
            cnt_q      <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> W;
          b_q     <= b_q >> W;
          res_q   <= res_d;
          carry_q <= cy;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            sum_q       <= sum_d;
            c_out_q     <= cy;
            ovf_q       <= ovf_d;
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.c_out     = c_out_q;
  assign io.overflow  = ovf_q;
  assign io.zero      = zero_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed and random add/sub against an arithmetic reference model,
// on the default (32/8) build plus the 32/32 and 16/1 configurations.
module tb_seq_addsub;
  import seq_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_addsub_if #(.N(32)) io8 ();
  seq_addsub_if #(.N(32)) io32 ();
  seq_addsub_if #(.N(16)) io1 ();
  state_e st8, st32, st1;

  seq_addsub #(.N(32), .W(8))  dut    (.clk(clk), .rst(rst), .io(io8),  .dbg_state_o(st8));
  seq_addsub #(.N(32), .W(32)) dut_32 (.clk(clk), .rst(rst), .io(io32), .dbg_state_o(st32));
  seq_addsub #(.N(16), .W(1))  dut_1  (.clk(clk), .rst(rst), .io(io1),  .dbg_state_o(st1));

  int n_pass  = 0;
  int n_total = 0;
  logic [34:0] exp_q[$];

  // Reference: {sum, c_out, overflow, zero} from plain signed/unsigned arithmetic.
  function automatic logic [34:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    longint mask, ua, ub, sa, sb, ur, sr, lim;
    logic c, v;
    logic [31:0] s;
    mask = (longint'(1) << n) - 1;
    lim  = longint'(1) << (n - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[n-1] ? ua - (mask + 1) : ua;
    sb = b[n-1] ? ub - (mask + 1) : ub;
    ur = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
    sr = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    c  = sub ? (ur >= 0) : (ur > mask);
    v  = (sr >= lim) || (sr < -lim);
    s  = 32'(ur & mask);
`ifdef SEQ_ADDSUB_SAT_EN
    if (v) s = (sa < 0) ? 32'(lim) : 32'(lim - 1);
`endif
    return {s, c, v, (s == 32'd0)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 32/8 instance, with `hold` cycles of result backpressure.
  task automatic run_op8(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, input int hold, input string tag);
    int lat;
    logic [34:0] exp, got;
    exp_q.push_back(model(32, a, b, sub, cin));
    io8.a = a; io8.b = b; io8.sub = sub; io8.c_in = cin; io8.in_valid = 1'b1;
    tick;
    io8.in_valid = 1'b0; io8.a = $urandom; io8.b = $urandom; io8.sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!io8.out_valid && lat < 64) begin tick; lat++; end
    n_total++;
    if (lat !== 4) $display("FAIL %s latency got %0d want 4", tag, lat);
    else n_pass++;
    exp = exp_q.pop_front();
    got = {io8.sum, io8.c_out, io8.overflow, io8.zero};
    n_total++;
    if (got !== exp) $display("FAIL %s result got %h want %h", tag, got, exp);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      io8.in_valid = 1'($urandom_range(0, 1)); io8.a = $urandom; io8.b = $urandom;
      tick;
      n_total++;
      if ({io8.in_ready, io8.out_valid, io8.sum, io8.c_out, io8.overflow, io8.zero} !== {2'b01, exp})
        $display("FAIL %s hold%0d got rdy=%b vld=%b res=%h want rdy=0 vld=1 res=%h", tag, i,
                 io8.in_ready, io8.out_valid, {io8.sum, io8.c_out, io8.overflow, io8.zero}, exp);
      else n_pass++;
    end
    io8.in_valid = 1'b0; io8.out_ready = 1'b1;
    tick;
    io8.out_ready = 1'b0;
    n_total++;
    if ({io8.out_valid, io8.in_ready, st8} !== {2'b01, IDLE})
      $display("FAIL %s release got vld=%b rdy=%b st=%0d want 0 1 0", tag, io8.out_valid,
               io8.in_ready, st8);
    else n_pass++;
  endtask

  task automatic test_reset;
    io8.in_valid = 0; io8.out_ready = 0; io8.a = 0; io8.b = 0; io8.sub = 0; io8.c_in = 0;
    io32.in_valid = 0; io32.out_ready = 0; io32.a = 0; io32.b = 0; io32.sub = 0; io32.c_in = 0;
    io1.in_valid = 0; io1.out_ready = 0; io1.a = 0; io1.b = 0; io1.sub = 0; io1.c_in = 0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    n_total++;
    if ({io8.in_ready, io8.out_valid, io8.sum, io8.c_out, io8.overflow, io8.zero, st8}
        !== {2'b10, 32'd0, 3'b000, IDLE})
      $display("FAIL reset got rdy=%b vld=%b sum=%h c=%b v=%b z=%b st=%0d want 1 0 0 0 0 0 0",
               io8.in_ready, io8.out_valid, io8.sum, io8.c_out, io8.overflow, io8.zero, st8);
    else n_pass++;
    n_total++;
    if ({io32.in_ready, io32.out_valid, io1.in_ready, io1.out_valid} !== 4'b1010)
      $display("FAIL reset_sweep got %b want 1010",
               {io32.in_ready, io32.out_valid, io1.in_ready, io1.out_valid});
    else n_pass++;
  endtask

  task automatic test_directed;
    run_op8(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0, "add_wrap");
    run_op8(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0, "add_ovf");
    run_op8(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, "add_neg_ovf");
    run_op8(32'd5, 32'd7, 1'b1, 1'b0, 0, "sub_borrow");
    run_op8(32'd7, 32'd5, 1'b1, 1'b1, 0, "sub_bin");
    run_op8(32'h8000_0000, 32'd1, 1'b1, 1'b0, 0, "sub_ovf");
  endtask

  task automatic test_backpressure;
    run_op8($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, "bp");
  endtask

  task automatic test_reset_mid_run;
    io8.a = 32'h1234_5678; io8.b = 32'h0F0F_0F0F; io8.sub = 0; io8.c_in = 1; io8.in_valid = 1;
    tick;
    io8.in_valid = 0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_total++;
    if ({io8.out_valid, io8.in_ready, io8.sum, st8} !== {2'b01, 32'd0, IDLE})
      $display("FAIL mid_rst got vld=%b rdy=%b sum=%h st=%0d want 0 1 0 0", io8.out_valid,
               io8.in_ready, io8.sum, st8);
    else n_pass++;
    run_op8(32'd2, 32'd3, 1'b0, 1'b0, 0, "after_rst");
  endtask

  task automatic test_random;
    for (int k = 0; k < 20; k++)
      run_op8($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), "rand8");
  endtask

  task automatic test_sweep_w32;
    int lat;
    logic [34:0] exp;
    for (int k = 0; k < 8; k++) begin
      io32.a = $urandom; io32.b = $urandom;
      if (k == 0) begin io32.a = 32'h7FFF_FFFF; io32.b = 32'd0; end
      io32.sub = 1'($urandom_range(0, 1)); io32.c_in = 1'($urandom_range(0, 1));
      if (k == 0) begin io32.sub = 1'b0; io32.c_in = 1'b1; end
      exp_q.push_back(model(32, io32.a, io32.b, io32.sub, io32.c_in));
      io32.in_valid = 1'b1;
      tick;
      io32.in_valid = 1'b0;
      lat = 0;
      while (!io32.out_valid && lat < 64) begin tick; lat++; end
      exp = exp_q.pop_front();
      n_total++;
      if (lat !== 1 || {io32.sum, io32.c_out, io32.overflow, io32.zero} !== exp)
        $display("FAIL w32 got lat=%0d res=%h want lat=1 res=%h", lat,
                 {io32.sum, io32.c_out, io32.overflow, io32.zero}, exp);
      else n_pass++;
      io32.out_ready = 1'b1;
      tick;
      io32.out_ready = 1'b0;
    end
  endtask

  task automatic test_sweep_w1;
    int lat;
    logic [34:0] exp;
    for (int k = 0; k < 8; k++) begin
      io1.a = 16'($urandom); io1.b = 16'($urandom);
      if (k == 0) begin io1.a = 16'h0003; io1.b = 16'h0003; end
      io1.sub = 1'($urandom_range(0, 1)); io1.c_in = 1'($urandom_range(0, 1));
      if (k == 0) begin io1.sub = 1'b1; io1.c_in = 1'b0; end
      exp_q.push_back(model(16, 32'(io1.a), 32'(io1.b), io1.sub, io1.c_in));
      io1.in_valid = 1'b1;
      tick;
      io1.in_valid = 1'b0;
      lat = 0;
      while (!io1.out_valid && lat < 64) begin tick; lat++; end
      exp = exp_q.pop_front();
      n_total++;
      if (lat !== 16 || {32'(io1.sum), io1.c_out, io1.overflow, io1.zero} !== exp)
        $display("FAIL w1 got lat=%0d res=%h want lat=16 res=%h", lat,
                 {32'(io1.sum), io1.c_out, io1.overflow, io1.zero}, exp);
      else n_pass++;
      io1.out_ready = 1'b1;
      tick;
      io1.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    test_sweep_w32;
    test_sweep_w1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
